// File: rtl/xs3_display_scanner_if.sv
// Capture/display bus between the Excess-3 adder stage and the display scanner.
// The master side supplies digits and strobes; the slave side drives the display pins and flags.
interface xs3_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic [3:0]        digit_in;
    logic              cout_in;
    logic              load;
    logic              clear;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              carry_led;
    logic              err;

    modport master (
        output digit_in, cout_in, load, clear,
        input  seg, an, carry_led, err
    );

    modport slave (
        input  digit_in, cout_in, load, clear,
        output seg, an, carry_led, err
    );
endinterface

// File: rtl/xs3_display_scanner.sv
// Buffers Excess-3 sum digits and scans them onto an active-low common-anode 7-segment display.
// Optional build macro XS3_LEADING_BLANK_EN blanks leading zero digits above digit 0.
module xs3_display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xs3_display_scanner_if.slave  bus
);

    localparam int               SEL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]       XS3_ZERO  = 4'b0011;
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RESET = ~DIGITS'(1);

    // Codes outside 0011..1100 do not represent a decimal digit.
    function automatic logic is_invalid(input logic [3:0] code);
        return (code < 4'b0011) || (code > 4'b1100);
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'b0011: pattern = 7'b1000000;
            4'b0100: pattern = 7'b1111001;
            4'b0101: pattern = 7'b0100100;
            4'b0110: pattern = 7'b0110000;
            4'b0111: pattern = 7'b0011001;
            4'b1000: pattern = 7'b0010010;
            4'b1001: pattern = 7'b0000010;
            4'b1010: pattern = 7'b1111000;
            4'b1011: pattern = 7'b0000000;
            4'b1100: pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    logic [3:0]       digit_buf_q [DIGITS];
    logic [3:0]       digit_buf_d [DIGITS];
    logic             any_invalid;
    logic             carry_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [6:0]       seg_d;
    logic [6:0]       seg_q;
    logic [DIGITS-1:0] an_d;
    logic [DIGITS-1:0] an_q;

    // Next buffer contents: clear beats load, load shifts in at index 0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        for (int i = 0; i < DIGITS; i++) begin
            digit_buf_d[i] = digit_buf_q[i];
        end
        if (bus.clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_d[i] = XS3_ZERO;
            end
        end else if (bus.load) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                digit_buf_d[i] = digit_buf_q[i-1];
            end
            digit_buf_d[0] = bus.digit_in;
        end
    end

    // err tracks the post-update buffer so it rises and falls on the same edge as the data.
    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid | is_invalid(digit_buf_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the digit buffer is a handful of flops, so it is reset like any other register.
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_q[i] <= XS3_ZERO;
            end
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_q[i] <= digit_buf_d[i];
            end
            if (bus.clear) begin
                carry_q <= 1'b0;
            end else if (bus.load) begin
                carry_q <= bus.cout_in;
            end
            err_q <= any_invalid;
        end
    end

    // Prescaler free-runs; capture and clear never disturb the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef XS3_LEADING_BLANK_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    logic [DIGITS-1:0] blank;
    logic              zero_run;

    // A digit is blank when it and everything above it is an Excess-3 zero; digit 0 never blanks.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (digit_buf_q[i] == XS3_ZERO);
            blank[i] = zero_run;
        end
    end

    always_comb begin
        seg_d = blank[sel_q] ? SEG_BLANK : decode(digit_buf_q[sel_q]);
        an_d  = ~(DIGITS'(1) << sel_q);
    end
`else
    always_comb begin
        seg_d = decode(digit_buf_q[sel_q]);
        an_d  = ~(DIGITS'(1) << sel_q);
    end
`endif

    // Anode and segment registers move together so the display never shows a mixed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_ZERO;
            an_q  <= AN_RESET;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.carry_led = carry_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_xs3_display_scanner.sv
// Directed bench for xs3_display_scanner with DIGITS=4, REFRESH_DIV=4.
// Expected values are hand-derived from the scan timing and the Excess-3 decode table.
module tb_xs3_display_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int CNT_W       = 16;

`ifdef XS3_LEADING_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    xs3_display_scanner_if #(.DIGITS(DIGITS)) bus ();

    xs3_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] a, input string tag);
        int n = 0;
        while (bus.an !== a && n < 40) begin
            tick();
            n++;
        end
        check({tag, " an reached"}, 32'(bus.an), 32'(a));
    endtask

    task automatic check_anode(input logic [3:0] a, input logic [6:0] exp, input string tag);
        wait_an(a, tag);
        check({tag, " seg"}, 32'(bus.seg), 32'(exp));
    endtask

    task automatic load_digit(input logic [3:0] d, input logic c);
        bus.digit_in = d;
        bus.cout_in  = c;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.digit_in = 4'b0000;
        bus.cout_in  = 1'b0;
        bus.load     = 1'b0;
        bus.clear    = 1'b0;

        // Reset state
        #23;
        check("rst an",    32'(bus.an),        32'b1110);
        check("rst seg",   32'(bus.seg),       32'b1000000);
        check("rst carry", 32'(bus.carry_led), 32'b0);
        check("rst err",   32'(bus.err),       32'b0);

        // Scan timing: anode 0 for 4 cycles, full period of 16
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("dwell0 cycle%0d", k), 32'(bus.an), 32'b1110);
        end
        tick();
        check("dwell1 start", 32'(bus.an), 32'b1101);
        repeat (11) tick();
        check("dwell3 end", 32'(bus.an), 32'b0111);
        tick();
        check("period wrap", 32'(bus.an), 32'b1110);

        // Two captures: 5 then 1 with carry
        load_digit(4'b1000, 1'b0);
        load_digit(4'b0100, 1'b1);
        check("carry after load", 32'(bus.carry_led), 32'b1);
        tick();
        check_anode(4'b1110, 7'b1111001, "d0=1");
        check_anode(4'b1101, 7'b0100100 ^ 7'b0110110, "d1=5");
        check_anode(4'b1011, LZ, "d2 lead");
        check_anode(4'b0111, LZ, "d3 lead");

        // Invalid code shows a dash on anode 0 one cycle after capture
        wait_an(4'b1110, "pre-invalid");
        load_digit(4'b1110, 1'b0);
        tick();
        check("dash seg", 32'(bus.seg), 32'b0111111);
        check("dash an",  32'(bus.an),  32'b1110);
        check("err set",  32'(bus.err), 32'b1);

        // Shift the invalid digit out with four valid captures
        load_digit(4'b0100, 1'b0);
        load_digit(4'b0101, 1'b0);
        load_digit(4'b0110, 1'b0);
        tick();
        check("err held", 32'(bus.err), 32'b1);
        load_digit(4'b0111, 1'b1);
        tick();
        check("err cleared", 32'(bus.err),       32'b0);
        check("carry set",   32'(bus.carry_led), 32'b1);
        check_anode(4'b1011, 7'b0100100, "shift d2=2");
        check_anode(4'b0111, 7'b1111001, "shift d3=1");

        // Clear wins over a simultaneous load of 9
        bus.digit_in = 4'b1100;
        bus.cout_in  = 1'b1;
        bus.load     = 1'b1;
        bus.clear    = 1'b1;
        tick();
        bus.load     = 1'b0;
        bus.clear    = 1'b0;
        check("clear carry", 32'(bus.carry_led), 32'b0);
        check("clear err",   32'(bus.err),       32'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            logic [6:0] exp_seg;
            exp_seg = (bus.an === 4'b1110) ? 7'b1000000 : LZ;
            check($sformatf("cleared scan %0d", i), 32'(bus.seg), 32'(exp_seg));
            tick();
        end

        // Asynchronous reset mid-dwell on anode 2
        load_digit(4'b1011, 1'b1);
        wait_an(4'b1011, "pre-reset");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst an",    32'(bus.an),        32'b1110);
        check("async rst seg",   32'(bus.seg),       32'b1000000);
        check("async rst carry", 32'(bus.carry_led), 32'b0);
        check("async rst err",   32'(bus.err),       32'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("restart an c%0d", k),  32'(bus.an),  32'b1110);
            check($sformatf("restart seg c%0d", k), 32'(bus.seg), 32'b1000000);
        end
        tick();
        check("restart dwell1", 32'(bus.an), 32'b1101);

        // Buffer {0011,0011,0101,0011}: leading-zero handling
        load_digit(4'b0101, 1'b0);
        load_digit(4'b0011, 1'b0);
        tick();
        check_anode(4'b1110, 7'b1000000, "lb d0");
        check_anode(4'b1101, 7'b0100100, "lb d1");
        check_anode(4'b1011, LZ,         "lb d2");
        check_anode(4'b0111, LZ,         "lb d3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
